// File: rtl/mo_pkg.sv
// Shared definitions for the cartridge loader: cartridge geometry, FSM states
// and the default download index that selects a cartridge image.
package mo_pkg;

    localparam int CART_BYTES = 16384;
    localparam int CART_AW    = 14;

    localparam logic [7:0] DEFAULT_CART_INDEX = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cart_loader.sv
// Cartridge loader: copies an HPS file download into cartridge RAM, pads the
// unloaded tail with FILL_BYTE, and reports size, checksum and overflow.
module cart_loader
    import mo_pkg::*;
#(
    parameter logic [7:0] CART_INDEX = DEFAULT_CART_INDEX,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                ioctl_wait,
    output logic [CART_AW-1:0]  mem_addr,
    output logic [7:0]          mem_din,
    output logic                mem_we,
    output logic                cart_inserted,
    output logic [14:0]         cart_size,
    output logic [7:0]          cart_sum,
    output logic                overflow
);

    state_t               state_q, state_d;
    logic                 dl_prev_q, dl_prev_d;
    logic                 armed_q, armed_d;
    logic                 pending_q, pending_d;
    logic [CART_AW-1:0]   fill_addr_q, fill_addr_d;
    logic [CART_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]           mem_din_q, mem_din_d;
    logic                 mem_we_q, mem_we_d;
    logic                 wait_q, wait_d;
    logic                 ins_q, ins_d;
    logic [14:0]          size_q, size_d;
    logic [7:0]           sum_q, sum_d;
    logic                 ovf_q, ovf_d;

    // armed_q keeps a download that is already high at reset release from
    // looking like a fresh rising edge.
    logic        dl_rise, dl_fall, start, wr_ok, in_range;
    logic [14:0] addr_plus1;

    assign dl_rise    = ioctl_download & ~dl_prev_q & armed_q;
    assign dl_fall    = ~ioctl_download & dl_prev_q;
    assign start      = dl_rise && (ioctl_index == CART_INDEX);
    assign wr_ok      = ioctl_wr && (ioctl_index == CART_INDEX);
    assign in_range   = (ioctl_addr[24:CART_AW] == '0);
    assign addr_plus1 = {1'b0, ioctl_addr[CART_AW-1:0]} + 15'd1;

    // Next-state and output computation for the IDLE/LOAD/FILL/DONE sequence.
    always_comb begin
        state_d     = state_q;
        dl_prev_d   = ioctl_download;
        armed_d     = armed_q | ~ioctl_download;
        pending_d   = pending_q;
        fill_addr_d = fill_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        ins_d       = ins_q;
        size_d      = size_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    size_d  = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    ins_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (wr_ok) begin
                    if (in_range) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = ioctl_addr[CART_AW-1:0];
                        mem_din_d  = ioctl_dout;
                        sum_d      = sum_q + ioctl_dout;
                        if (addr_plus1 > size_q) begin
                            size_d = addr_plus1;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // The decision uses size_d so a final byte in this cycle counts.
                if (dl_fall) begin
                    if (size_d == 15'(CART_BYTES)) begin
                        state_d = ST_DONE;
                        ins_d   = 1'b1;
                    end else begin
                        state_d     = ST_FILL;
                        fill_addr_d = size_d[CART_AW-1:0];
                    end
                end
            end
            ST_FILL: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = fill_addr_q;
                mem_din_d   = FILL_BYTE;
                fill_addr_d = fill_addr_q + 1'b1;
                if (start) begin
                    pending_d = 1'b1;
                end
                if (fill_addr_q == '1) begin
                    if (pending_d) begin
                        // A new image arrived during padding: go straight to it.
                        state_d   = ST_LOAD;
                        pending_d = 1'b0;
                        size_d    = '0;
                        sum_d     = '0;
                        ovf_d     = 1'b0;
                        ins_d     = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        ins_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wait_d = (state_d == ST_FILL);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dl_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
            pending_q   <= 1'b0;
            fill_addr_q <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            wait_q      <= 1'b0;
            ins_q       <= 1'b0;
            size_q      <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_prev_q   <= dl_prev_d;
            armed_q     <= armed_d;
            pending_q   <= pending_d;
            fill_addr_q <= fill_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            wait_q      <= wait_d;
            ins_q       <= ins_d;
            size_q      <= size_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ioctl_wait    = wait_q;
    assign mem_addr      = mem_addr_q;
    assign mem_din       = mem_din_q;
    assign mem_we        = mem_we_q;
    assign cart_inserted = ins_q;
    assign cart_size     = size_q;
    assign cart_sum      = sum_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_cart_loader.sv
// Randomized bench for cart_loader: the bench predicts every RAM write (with
// the cycle it must appear on), the ioctl_wait window and the final status
// from the loader's rules, and a per-cycle compare process checks the DUT.
module tb_cart_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd1;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic [13:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        cart_inserted;
    logic [14:0] cart_size;
    logic [7:0]  cart_sum;
    logic        overflow;

    cart_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_we         (mem_we),
        .cart_inserted  (cart_inserted),
        .cart_size      (cart_size),
        .cart_sum       (cart_sum),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  wait_lo = 1;
    int  wait_hi = 0;
    int  we_cnt = 0;
    int  wait_cnt = 0;
    int  ins_cnt = 0;
    int  last_we_addr = -1;
    int  fill_end = 0;

    // Reference status of the current cartridge image.
    int  m_size = 0;
    int  m_sum = 0;
    int  m_ovf = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle check of the write port and the stall signal.
    int  cmp_we;
    int  cmp_wait;
    always @(negedge clk) begin
        cmp_we = (exp_q.size() > 0 && exp_q[0].cyc == cyc) ? 1 : 0;
        chk("mem_we", int'(mem_we), cmp_we);
        if (cmp_we != 0) begin
            chk("mem_addr", int'(mem_addr), exp_q[0].addr);
            chk("mem_din", int'(mem_din), exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (mem_we) begin
            we_cnt++;
            last_we_addr = int'(mem_addr);
        end
        cmp_wait = (cyc >= wait_lo && cyc <= wait_hi) ? 1 : 0;
        chk("ioctl_wait", int'(ioctl_wait), cmp_wait);
        if (cmp_wait != 0) chk("ins_during_fill", int'(cart_inserted), 0);
        if (ioctl_wait) wait_cnt++;
        if (cart_inserted) ins_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_until(input int n);
        while (cyc < n) step();
    endtask

    task automatic start_dl(input int idx);
        ioctl_index    = idx[7:0];
        ioctl_download = 1'b1;
        if (idx == 1) begin
            m_size = 0;
            m_sum  = 0;
            m_ovf  = 0;
        end
        we_cnt = 0;
        step();
    endtask

    task automatic wr_byte(input int addr, input int data, input bit match);
        wr_t w;
        ioctl_addr = addr[24:0];
        ioctl_dout = data[7:0];
        ioctl_wr   = 1'b1;
        if (match) begin
            if (addr < 16384) begin
                w.cyc  = cyc + 1;
                w.addr = addr;
                w.data = data & 255;
                exp_q.push_back(w);
                m_sum = (m_sum + data) & 255;
                if (addr + 1 > m_size) m_size = addr + 1;
            end else begin
                m_ovf = 1;
            end
        end
        step();
    endtask

    task automatic end_dl(input bit match);
        wr_t w;
        int  c;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        c = cyc;
        if (match) begin
            if (m_size < 16384) begin
                for (int k = 0; k < 16384 - m_size; k++) begin
                    w.cyc  = c + 2 + k;
                    w.addr = m_size + k;
                    w.data = 255;
                    exp_q.push_back(w);
                end
                wait_lo  = c + 1;
                wait_hi  = c + 16384 - m_size;
                fill_end = c + 1 + 16384 - m_size;
            end else begin
                fill_end = c + 1;
            end
        end
        wait_cnt = 0;
        step();
    endtask

    task automatic check_status(input string tag, input int ins);
        chk({tag, "_inserted"}, int'(cart_inserted), ins);
        chk({tag, "_size"}, int'(cart_size), m_size);
        chk({tag, "_sum"}, int'(cart_sum), m_sum);
        chk({tag, "_overflow"}, int'(overflow), m_ovf);
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, int'(mem_we), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_din"}, int'(mem_din), 0);
        chk({tag, "_wait"}, int'(ioctl_wait), 0);
        chk({tag, "_inserted"}, int'(cart_inserted), 0);
        chk({tag, "_size"}, int'(cart_size), 0);
        chk({tag, "_sum"}, int'(cart_sum), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fe1;
        int a;

        // Reset state.
        repeat (3) step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) step();

        // Full 16384-byte image, data = addr[7:0]: no padding.
        start_dl(1);
        for (int i = 0; i < 16384; i++) wr_byte(i, i & 255, 1'b1);
        end_dl(1'b1);
        run_until(fill_end + 1);
        chk("full_size_lit", int'(cart_size), 16384);
        chk("full_sum_lit", int'(cart_sum), 0);
        chk("full_writes_lit", we_cnt, 16384);
        check_status("full", 1);
        $display("full load: size=%0d sum=%02h inserted=%0d writes=%0d", cart_size, cart_sum, cart_inserted, we_cnt);
        repeat (2) step();

        // Foreign-index download while DONE: ignored.
        start_dl(0);
        for (int i = 0; i < 8; i++) wr_byte(i, 8'hA5, 1'b0);
        end_dl(1'b0);
        repeat (3) step();
        chk("foreign_writes", we_cnt, 0);
        check_status("foreign", 1);
        $display("foreign index: inserted=%0d size=%0d writes=%0d", cart_inserted, cart_size, we_cnt);

        // Half image of 8'h55: padded with FILL_BYTE, 8192 stall cycles.
        start_dl(1);
        for (int i = 0; i < 8192; i++) wr_byte(i, 8'h55, 1'b1);
        end_dl(1'b1);
        run_until(fill_end + 1);
        chk("half_wait_cycles_lit", wait_cnt, 8192);
        chk("half_size_lit", int'(cart_size), 8192);
        chk("half_sum_lit", int'(cart_sum), 0);
        check_status("half", 1);
        $display("half load: size=%0d sum=%02h wait_cycles=%0d", cart_size, cart_sum, wait_cnt);
        repeat (2) step();

        // Oversized 16400-byte file.
        start_dl(1);
        for (int i = 0; i < 16400; i++) wr_byte(i, int'($urandom_range(0, 255)), 1'b1);
        end_dl(1'b1);
        run_until(fill_end + 1);
        chk("over_flag_lit", int'(overflow), 1);
        chk("over_size_lit", int'(cart_size), 16384);
        chk("over_last_addr_lit", last_we_addr, 16383);
        chk("over_writes_lit", we_cnt, 16384);
        check_status("over", 1);
        $display("oversize load: overflow=%0d size=%0d last_addr=%0d", overflow, cart_size, last_we_addr);
        repeat (2) step();

        // Reset in the middle of a load, download still high at release.
        start_dl(1);
        for (int i = 0; i < 100; i++) wr_byte(i, int'($urandom_range(0, 255)), 1'b1);
        ioctl_wr = 1'b0;
        reset_n  = 1'b0;
        exp_q.delete();
        wait_lo  = 1;
        wait_hi  = 0;
        m_size   = 0;
        m_sum    = 0;
        m_ovf    = 0;
        #1;
        check_reset_outputs("midload_reset");
        repeat (2) step();
        reset_n = 1'b1;
        we_cnt  = 0;
        for (int i = 0; i < 20; i++) wr_byte(100 + i, 8'h3C, 1'b0);
        ioctl_wr = 1'b0;
        step();
        chk("post_reset_writes", we_cnt, 0);
        check_status("post_reset", 0);
        ioctl_download = 1'b0;
        repeat (2) step();
        $display("reset mid-load: inserted=%0d size=%0d writes_after=%0d", cart_inserted, cart_size, we_cnt);

        // Random bytes at random high addresses, some beyond the cartridge.
        start_dl(1);
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                ioctl_wr = 1'b0;
                step();
            end
            a = int'($urandom_range(12000, 16500));
            wr_byte(a, int'($urandom_range(0, 255)), 1'b1);
        end
        end_dl(1'b1);
        run_until(fill_end + 1);
        check_status("random", 1);
        $display("random load: size=%0d sum=%02h overflow=%0d", cart_size, cart_sum, overflow);
        repeat (2) step();

        // New download arriving during padding, then a zero-byte image.
        start_dl(1);
        ins_cnt = 0;
        for (int i = 0; i < 20; i++) wr_byte(int'($urandom_range(16000, 16300)), int'($urandom_range(0, 255)), 1'b1);
        end_dl(1'b1);
        fe1 = fill_end;
        run_until(wait_lo + 10);
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        step();
        run_until(fe1 + 3);
        m_size = 0;
        m_sum  = 0;
        m_ovf  = 0;
        chk("pending_ins_count", ins_cnt, 0);
        chk("pending_wait", int'(ioctl_wait), 0);
        check_status("pending_reload", 0);
        end_dl(1'b1);
        run_until(fill_end + 1);
        chk("zero_size_lit", int'(cart_size), 0);
        chk("zero_wait_cycles_lit", wait_cnt, 16384);
        check_status("zero", 1);
        $display("pending + zero-byte load: size=%0d inserted=%0d wait_cycles=%0d", cart_size, cart_inserted, wait_cnt);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 Parameter CART_INDEX, default 1: ioctl_index value that selects a cartridge download.
REQ-002 Parameter FILL_BYTE, default 8'hFF: byte written to unloaded cartridge locations.
REQ-003 clk  in  1  system clock; every register is clocked on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  high while the HPS file transfer is in progress.
REQ-006 ioctl_index  in  8  transfer type.
REQ-007 ioctl_wr  in  1  one-cycle strobe; ioctl_addr/ioctl_dout valid.
REQ-008 ioctl_addr  in  25  byte address within the file.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 ioctl_wait  out  1  stall request to the HPS.
REQ-011 mem_addr  out  14  cartridge RAM write address.
REQ-012 mem_din  out  8  cartridge RAM write data.
REQ-013 mem_we  out  1  cartridge RAM write enable, one write per cycle.
REQ-014 cart_inserted  out  1  a complete image is present in cartridge RAM.
REQ-015 cart_size  out  15  bytes accepted from the file, 0..16384.
REQ-016 cart_sum  out  8  modulo-256 sum of accepted bytes.
REQ-017 overflow  out  1  the file exceeded 16384 bytes.

Function
REQ-018 States: IDLE, LOAD, FILL, DONE; encoding is free.
REQ-019 IDLE/DONE -> LOAD on the rising edge of ioctl_download with ioctl_index==CART_INDEX. On entry: cart_size, cart_sum and overflow clear; cart_inserted drops in the same cycle.
REQ-020 Downloads with another index are ignored in every state: no writes, no status change.
REQ-021 LOAD, ioctl_wr with ioctl_addr<16384: next cycle mem_we=1, mem_addr=ioctl_addr[13:0], mem_din=ioctl_dout (latency 1).
REQ-021a On that byte, cart_sum+=ioctl_dout (mod 256) and cart_size=max(cart_size, ioctl_addr+1).
REQ-022 LOAD, ioctl_wr with ioctl_addr>=16384: no write, overflow=1, cart_size/cart_sum unchanged.
REQ-023 LOAD -> FILL on ioctl_download falling edge when cart_size<16384; LOAD -> DONE when cart_size==16384.
REQ-024 FILL: one write per cycle, mem_din=FILL_BYTE, addresses cart_size..16383 ascending; after writing 16383 -> DONE.
REQ-025 DONE: cart_inserted=1, mem_we=0; outputs hold until the next matching download.
REQ-026 Zero-byte download (ioctl_download pulse, no ioctl_wr): FILL covers 0..16383, cart_size=0.
REQ-027 ioctl_wait=1 only in FILL. A matching download rising edge seen during FILL is latched and taken on FILL completion: DONE is skipped, cart_inserted stays 0.
REQ-028 Outside LOAD and FILL, mem_we=0. mem_we is never high two cycles in a row for the same address in LOAD unless two strobes repeat that address.
REQ-029 Size arithmetic is 15-bit; 16384 is the only value with bit 14 set.

Reset
REQ-030 reset_n low: state=IDLE, mem_we=0, mem_addr=0, mem_din=0, ioctl_wait=0, cart_inserted=0, cart_size=0, cart_sum=0, overflow=0, pending-start latch cleared.
REQ-031 Reset asserted mid-LOAD or mid-FILL aborts at once; cartridge RAM contents are undefined and cart_inserted=0 until a new complete load.
REQ-032 ioctl_download edge detector resets to 0; a download already high at reset release is not taken as a start.

Structure
REQ-033 Shared package mo_pkg: CART_BYTES=16384, CART_AW=14, state typedef, default CART_INDEX.
REQ-034 Single module, no sub-modules; output feeds cartridge RAM write port directly (addr_wr, din, we).

Verification
REQ-035 Load 16384 bytes data=addr[7:0] -> 16384 writes at latency 1, no FILL, cart_size=16384, cart_sum=8'h00, cart_inserted=1.
REQ-036 Load 8192 bytes of 8'h55 -> FILL writes 8'hFF to 8192..16383 with ioctl_wait high 8192 cycles, then cart_size=8192, cart_sum=8'h00.
REQ-037 Load 16400 bytes -> overflow=1, last write addr 16383, cart_size=16384, no write for 16384..16399.
REQ-038 Download with ioctl_index=0 during DONE -> no mem_we, cart_inserted stays 1.
REQ-039 reset_n pulsed low at byte 100 of a load -> all outputs per REQ-030 next edge, no writes until a new download.
REQ-040 New matching download starting mid-FILL -> FILL completes, then LOAD, cart_inserted never 1 between.
